// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Round-robin arbiter/sequencer sharing one single-port RAM between NREQ
//   requesters (default order: 0=icache0, 1=dcache0, 2=icache1, 3=dcache1).
//   A grant is made in IDLE and held in XFER until the RAM answers ACCESS or
//   ERROR, or until the granted requester withdraws. One IDLE bubble always
//   separates two transfers.
//
//   Optional feature macro: RAM_ARB_TIMEOUT_EN
//     When defined, a transfer that sees neither ACCESS nor ERROR for TIMEOUT
//     XFER cycles is released and reported through xfer_err. When undefined,
//     XFER waits indefinitely and TIMEOUT has no effect.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   req_ren/req_wen     per-requester read/write request (write wins)
//   req_addr/req_store  flattened per-requester address / write data
//   req_wait            1 = requester must hold its request
//   req_load            RAM read data broadcast to all requesters
//   ramREN/ramWEN       RAM enables, ramaddr/ramstore RAM address/data
//   ramload/ramstate    RAM read data and status (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   grant_vld/grant_id  registered grant status
//   xfer_err            one-cycle pulse after an ERROR (or timeout) release
module ram_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [DATA_W-1:0]        req_load,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     grant_vld,
    output logic [IDW-1:0]           grant_id,
    output logic                     xfer_err
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  grant_id_q;
    logic            grant_vld_q;
    logic            xfer_err_q;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q;
`endif

    logic [NREQ-1:0] req;
    logic [IDW-1:0]  winner_d;
    logic            found;
    logic            g_req, g_ren, g_wen;
    logic            timeout_hit;
    logic            rel_ok, rel_err;
    logic [IDW-1:0]  rr_ptr_d;

    always_comb begin
        req      = req_ren | req_wen;
        winner_d = '0;
        found    = 1'b0;
        // First requester at or after rr_ptr, wrapping modulo NREQ.
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr_ptr_q) + k) % NREQ]) begin
                found    = 1'b1;
                winner_d = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end

        g_req = req[grant_id_q];
        g_ren = req_ren[grant_id_q];
        g_wen = req_wen[grant_id_q];

`ifdef RAM_ARB_TIMEOUT_EN
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
        timeout_hit = 1'b0;
`endif

        // A withdrawn request ends the transfer silently, so it masks release.
        rel_ok  = grant_vld_q && g_req && (ramstate == RS_ACCESS);
        rel_err = grant_vld_q && g_req && !rel_ok &&
                  ((ramstate == RS_ERROR) || timeout_hit);

        rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);

        req_wait = req;
        if (rel_ok || rel_err)
            req_wait[grant_id_q] = 1'b0;

        // RAM side follows the granted requester's live request lines.
        ramWEN   = grant_vld_q && g_wen;
        ramREN   = grant_vld_q && g_ren && !g_wen;
        ramaddr  = grant_vld_q ? req_addr[int'(grant_id_q)*ADDR_W +: ADDR_W]   : '0;
        ramstore = grant_vld_q ? req_store[int'(grant_id_q)*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            xfer_err_q  <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            xfer_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q     <= XFER;
                        grant_vld_q <= 1'b1;
                        grant_id_q  <= winner_d;
`ifdef RAM_ARB_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                XFER: begin
                    if (!g_req) begin
                        state_q     <= IDLE;
                        grant_vld_q <= 1'b0;
                    end else if (rel_ok) begin
                        state_q     <= IDLE;
                        grant_vld_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                    end else if (rel_err) begin
                        state_q     <= IDLE;
                        grant_vld_q <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        xfer_err_q  <= 1'b1;
                    end else begin
`ifdef RAM_ARB_TIMEOUT_EN
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    grant_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_load  = ramload;
    assign grant_vld = grant_vld_q;
    assign grant_id  = grant_id_q;
    assign xfer_err  = xfer_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter (NREQ=4, 32-bit address/data, TIMEOUT=8).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge of the same cycle.
module tb_ram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NREQ-1:0] req_ren, req_wen;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [NREQ-1:0] req_wait;
    logic [DW-1:0]   req_load;
    logic            ramREN, ramWEN;
    logic [AW-1:0]   ramaddr;
    logic [DW-1:0]   ramstore;
    logic [DW-1:0]   ramload;
    logic [1:0]      ramstate;
    logic            grant_vld;
    logic [1:0]      grant_id;
    logic            xfer_err;

    int n_chk  = 0;
    int n_fail = 0;

    ram_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant_vld(grant_vld), .grant_id(grant_id), .xfer_err(xfer_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        // Reset with every requester active
        RST = 1'b1; req_ren = 4'b1111; req_wen = 4'b0000;
        req_addr = '0; req_store = '0; ramload = '0; ramstate = FREE;
        cyc(); smp();
        chk_eq("rst_vld",  grant_vld, 0);
        chk_eq("rst_err",  xfer_err,  0);
        chk_eq("rst_ren",  ramREN,    0);
        chk_eq("rst_wen",  ramWEN,    0);
        chk_eq("rst_addr", ramaddr,   0);
        chk_eq("rst_wait", req_wait,  4'b1111);
        cyc(); RST = 1'b0; req_ren = '0;

        // Single read from requester 1
        cyc();
        req_ren[1] = 1'b1; req_addr[1*AW +: AW] = 32'h40; ramstate = BUSY;
        smp();
        chk_eq("rd_idle_wait", req_wait, 4'b0010);
        chk_eq("rd_idle_ren",  ramREN,   0);
        cyc(); smp();
        chk_eq("rd_vld",  grant_vld, 1);
        chk_eq("rd_id",   grant_id,  1);
        chk_eq("rd_ren",  ramREN,    1);
        chk_eq("rd_addr", ramaddr,   32'h40);
        chk_eq("rd_wait_busy1", req_wait, 4'b0010);
        cyc(); smp();
        chk_eq("rd_wait_busy2", req_wait, 4'b0010);
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; smp();
        chk_eq("rd_wait_acc", req_wait, 4'b0000);
        chk_eq("rd_load",     req_load, 32'hDEADBEEF);
        cyc(); req_ren = '0; ramstate = FREE; smp();
        chk_eq("rd_done_vld", grant_vld, 0);

        // Round-robin with all four requesting, one-cycle RAM accesses
        cyc(); RST = 1'b1; smp();
        cyc(); RST = 1'b0; req_ren = 4'b1111; ramstate = ACCESS; smp();
        chk_eq("rr_vld_0", grant_vld, 0);
        for (int k = 1; k < 10; k++) begin
            cyc(); smp();
            chk_eq($sformatf("rr_vld_%0d", k), grant_vld, 64'(k % 2));
            if (k % 2 == 1)
                chk_eq($sformatf("rr_id_%0d", k), grant_id, 64'(order[(k-1)/2]));
        end
        cyc(); req_ren = '0; ramstate = FREE; smp();

        // Write priority on requester 3, then withdraw mid-BUSY
        cyc();
        req_ren[3] = 1'b1; req_wen[3] = 1'b1; ramstate = BUSY;
        req_addr[3*AW +: AW] = 32'h300; req_store[3*DW +: DW] = 32'h12345678;
        smp();
        cyc(); smp();
        chk_eq("wr_vld",   grant_vld, 1);
        chk_eq("wr_id",    grant_id,  3);
        chk_eq("wr_wen",   ramWEN,    1);
        chk_eq("wr_ren",   ramREN,    0);
        chk_eq("wr_addr",  ramaddr,   32'h300);
        chk_eq("wr_store", ramstore,  32'h12345678);
        chk_eq("wr_wait",  req_wait,  4'b1000);
        cyc(); req_ren = '0; req_wen = '0; smp();
        chk_eq("ab_wen",  ramWEN,   0);
        chk_eq("ab_ren",  ramREN,   0);
        chk_eq("ab_wait", req_wait, 4'b0000);
        cyc(); smp();
        chk_eq("ab_vld", grant_vld, 0);
        chk_eq("ab_err", xfer_err,  0);

        // Error on grant to 2; rr_ptr still 1 so {0,2,3} picks 2
        cyc(); req_ren = 4'b1101; smp();
        cyc(); smp();
        chk_eq("er_id", grant_id, 2);
        cyc(); ramstate = ERROR; smp();
        chk_eq("er_wait",    req_wait, 4'b1001);
        chk_eq("er_err_pre", xfer_err, 0);
        cyc(); req_ren = 4'b1001; ramstate = BUSY; smp();
        chk_eq("er_err_pulse", xfer_err,  1);
        chk_eq("er_vld",       grant_vld, 0);
        cyc(); req_ren = 4'b1000; smp();
        chk_eq("er_next_vld", grant_vld, 1);
        chk_eq("er_next_id",  grant_id,  3);
        chk_eq("er_err_end",  xfer_err,  0);

        // RAM stuck BUSY on grant to 3 (first XFER cycle already current)
`ifdef RAM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            if (k != 1) begin cyc(); smp(); end
            chk_eq($sformatf("to_wait_%0d", k), req_wait[3], (k == 8) ? 64'd0 : 64'd1);
            chk_eq($sformatf("to_vld_%0d", k),  grant_vld, 1);
        end
        cyc(); req_ren = '0; ramstate = FREE; smp();
        chk_eq("to_err", xfer_err,  1);
        chk_eq("to_vld", grant_vld, 0);
`else
        for (int k = 1; k <= 100; k++) begin
            if (k != 1) begin cyc(); smp(); end
            chk_eq($sformatf("hold_vld_%0d", k),  grant_vld,   1);
            chk_eq($sformatf("hold_wait_%0d", k), req_wait[3], 1);
        end
        cyc(); ramstate = ACCESS; smp();
        chk_eq("hold_release_wait", req_wait[3], 0);
        cyc(); req_ren = '0; ramstate = FREE; smp();
        chk_eq("hold_release_vld", grant_vld, 0);
        chk_eq("hold_release_err", xfer_err,  0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
